// File: rtl/crossfade_sequencer.sv
// Crossfade controller: owns the complementary mixer gains, applies manual button nudges
// and runs timed automatic fades toward a target weight, stepped on sample strobes.
module crossfade_sequencer #(
  parameter int unsigned MAX_WEIGHT    = 31,
  parameter int unsigned CENTER_WEIGHT = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ready,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             fade_start,
  input  logic [4:0]       fade_target,
  input  logic [CNT_W-1:0] step_interval,
  output logic [4:0]       weight1,
  output logic [4:0]       weight2,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] MaxW    = 5'(MAX_WEIGHT);
  localparam logic [4:0] CenterW = 5'(CENTER_WEIGHT);

  typedef enum logic [0:0] {StIdle, StFading} state_e;

  state_e           state_q, state_d;
  logic [4:0]       weight1_q, weight1_d;
  logic [4:0]       weight2_q, weight2_d;
  logic [4:0]       target_q, target_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             old_up_q, old_up_d;
  logic             old_down_q, old_down_d;

  logic             up_edge, down_edge;
  logic [4:0]       inc_weight, dec_weight, step_weight;
  logic [CNT_W-1:0] interval_eff;
  logic             last_strobe;

  assign up_edge   = btn_up & ~old_up_q;
  assign down_edge = btn_down & ~old_down_q;

  assign inc_weight = (weight1_q >= MaxW) ? MaxW : weight1_q + 5'd1;
  assign dec_weight = (weight1_q == 5'd0) ? 5'd0 : weight1_q - 5'd1;

  // While fading the target never equals the current weight, so this always moves one unit.
  assign step_weight = (weight1_q < target_q) ? inc_weight : dec_weight;

  assign interval_eff = (step_interval == '0) ? CNT_W'(1) : step_interval;
  assign last_strobe  = (cnt_q == interval_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    weight1_d  = weight1_q;
    target_d   = target_q;
    interval_d = interval_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    old_up_d   = btn_up;
    old_down_d = btn_down;

    unique case (state_q)
      StIdle: begin
        if (fade_start) begin
          if (fade_target == weight1_q) begin
            done_d = 1'b1;
          end else begin
            target_d   = fade_target;
            interval_d = interval_eff;
            cnt_d      = '0;
            state_d    = StFading;
          end
        end else if (up_edge && !down_edge) begin
          weight1_d = inc_weight;
        end else if (down_edge && !up_edge) begin
          weight1_d = dec_weight;
        end
      end

      StFading: begin
        if (fade_start) begin
          // Retarget wins over a simultaneous abort or step.
          cnt_d = '0;
          if (fade_target == weight1_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            target_d   = fade_target;
            interval_d = interval_eff;
          end
        end else if (up_edge || down_edge) begin
          // Abort: the edge is consumed and the weight holds.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (ready) begin
          if (last_strobe) begin
            cnt_d     = '0;
            weight1_d = step_weight;
            if (step_weight == target_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase

    weight2_d = MaxW - weight1_d;
    busy_d    = (state_d == StFading);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      weight1_q  <= CenterW;
      weight2_q  <= MaxW - CenterW;
      target_q   <= CenterW;
      interval_q <= CNT_W'(1);
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      old_up_q   <= 1'b0;
      old_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      weight1_q  <= weight1_d;
      weight2_q  <= weight2_d;
      target_q   <= target_d;
      interval_q <= interval_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      old_up_q   <= old_up_d;
      old_down_q <= old_down_d;
    end
  end

  assign weight1 = weight1_q;
  assign weight2 = weight2_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_crossfade_sequencer.sv
// Self-checking bench for crossfade_sequencer: a vector table for reset and manual nudging,
// hand-written sequences for fades, aborts, retargets and mid-fade reset.
module tb_crossfade_sequencer;

  logic        clock = 1'b0;
  logic        reset_n, ready, btn_up, btn_down, fade_start;
  logic [4:0]  fade_target;
  logic [15:0] step_interval;
  logic [4:0]  weight1, weight2;
  logic        busy, done;

  crossfade_sequencer #(
    .MAX_WEIGHT   (31),
    .CENTER_WEIGHT(16),
    .CNT_W        (16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ready        (ready),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .fade_start   (fade_start),
    .fade_target  (fade_target),
    .step_interval(step_interval),
    .weight1      (weight1),
    .weight2      (weight2),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rn, rdy, up, dn, fs;
    logic [4:0]  ft;
    logic [15:0] si;
    logic [4:0]  w1;
    logic        busy, done;
  } vec_t;

  typedef struct {
    logic [4:0] w1;
    logic       busy, done;
    int         step;
  } exp_t;

  vec_t  vecs[$];
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    step_no = 0;
  string phase = "init";

  function automatic void add(input logic rn, rdy, up, dn, fs, input logic [4:0] ft,
                              input logic [15:0] si, input logic [4:0] w1,
                              input logic eb, ed);
    vec_t v;
    v.rn = rn; v.rdy = rdy; v.up = up; v.dn = dn; v.fs = fs;
    v.ft = ft; v.si = si; v.w1 = w1; v.busy = eb; v.done = ed;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string nm, input int stp, input logic [4:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s step %0d: got %0d, expected %0d", phase, nm, stp, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t       e;
    logic [4:0] w2;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", phase);
      return;
    end
    e  = exp_q.pop_front();
    w2 = 5'd31 - e.w1;
    cmp("weight1", e.step, weight1, e.w1);
    cmp("weight2", e.step, weight2, w2);
    cmp("busy", e.step, {4'd0, busy}, {4'd0, e.busy});
    cmp("done", e.step, {4'd0, done}, {4'd0, e.done});
  endtask

  task automatic tick(input logic rn, rdy, up, dn, fs, input logic [4:0] ft,
                      input logic [15:0] si, input logic [4:0] ew, input logic eb, ed);
    exp_t e;
    reset_n = rn; ready = rdy; btn_up = up; btn_down = dn;
    fade_start = fs; fade_target = ft; step_interval = si;
    step_no++;
    e.w1 = ew; e.busy = eb; e.done = ed; e.step = step_no;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic idle(input logic [4:0] ew, input logic eb);
    tick(1, 0, 0, 0, 0, 5'd0, 16'd0, ew, eb, 0);
  endtask

  task automatic strobe(input logic [4:0] ew, input logic eb, ed);
    tick(1, 1, 0, 0, 0, 5'd0, 16'd0, ew, eb, ed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and manual saturation table.
    repeat (3) add(0, 0, 0, 0, 0, 5'd0, 16'd0, 5'd16, 0, 0);
    add(1, 0, 0, 0, 0, 5'd0, 16'd0, 5'd16, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      int w;
      w = (16 + i > 31) ? 31 : 16 + i;
      add(1, 0, 1, 0, 0, 5'd0, 16'd0, 5'(w), 0, 0);
      add(1, 0, 0, 0, 0, 5'd0, 16'd0, 5'(w), 0, 0);
    end
    for (int i = 1; i <= 40; i++) begin
      int w;
      w = (31 - i < 0) ? 0 : 31 - i;
      add(1, 0, 0, 1, 0, 5'd0, 16'd0, 5'(w), 0, 0);
      add(1, 0, 0, 0, 0, 5'd0, 16'd0, 5'(w), 0, 0);
    end
    add(1, 0, 1, 0, 0, 5'd0, 16'd0, 5'd1, 0, 0);
    add(1, 0, 0, 0, 0, 5'd0, 16'd0, 5'd1, 0, 0);
    add(1, 0, 1, 1, 0, 5'd0, 16'd0, 5'd1, 0, 0);
    add(1, 0, 0, 0, 0, 5'd0, 16'd0, 5'd1, 0, 0);

    phase = "table";
    foreach (vecs[i])
      tick(vecs[i].rn, vecs[i].rdy, vecs[i].up, vecs[i].dn, vecs[i].fs, vecs[i].ft,
           vecs[i].si, vecs[i].w1, vecs[i].busy, vecs[i].done);

    // Auto fade 16 -> 20, interval 4, ready every 10 cycles.
    phase = "fade4";
    tick(0, 0, 0, 0, 0, 5'd0, 16'd0, 5'd16, 0, 0);
    idle(5'd16, 0);
    tick(1, 0, 0, 0, 1, 5'd20, 16'd4, 5'd16, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      repeat (9) idle(5'(16 + (k - 1) / 4), 1);
      strobe(5'(16 + k / 4), k < 16, k == 16);
    end
    idle(5'd20, 0);

    // Interval 0 behaves as 1: 20 -> 24, one step per strobe.
    phase = "fade0";
    tick(1, 0, 0, 0, 1, 5'd24, 16'd0, 5'd20, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (2) idle(5'(20 + k - 1), 1);
      strobe(5'(20 + k), k < 4, k == 4);
    end
    idle(5'd24, 0);

    // Abort 16 -> 0 fade at 13 with btn_up.
    phase = "abort";
    tick(0, 0, 0, 0, 0, 5'd0, 16'd0, 5'd16, 0, 0);
    idle(5'd16, 0);
    tick(1, 0, 0, 0, 1, 5'd0, 16'd2, 5'd16, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      idle(5'(16 - (k - 1) / 2), 1);
      strobe(5'(16 - k / 2), 1, 0);
    end
    tick(1, 0, 1, 0, 0, 5'd0, 16'd0, 5'd13, 0, 0);
    idle(5'd13, 0);
    strobe(5'd13, 0, 0);
    tick(1, 0, 1, 0, 0, 5'd0, 16'd0, 5'd14, 0, 0);
    idle(5'd14, 0);

    // Retarget at 10 (with counter one short of a step and a coincident strobe) to 12.
    phase = "retarget";
    tick(1, 0, 0, 0, 1, 5'd0, 16'd2, 5'd14, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      idle(5'(14 - (k - 1) / 2), 1);
      strobe(5'(14 - k / 2), 1, 0);
    end
    tick(1, 1, 0, 0, 1, 5'd12, 16'd2, 5'd10, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (2) idle(5'(10 + (k - 1) / 2), 1);
      strobe(5'(10 + k / 2), k < 4, k == 4);
    end
    idle(5'd12, 0);

    // Degenerate start in IDLE, then degenerate retarget while fading.
    phase = "degenerate";
    tick(1, 0, 0, 0, 1, 5'd12, 16'd5, 5'd12, 0, 1);
    idle(5'd12, 0);
    tick(1, 0, 0, 0, 1, 5'd31, 16'd1, 5'd12, 1, 0);
    strobe(5'd13, 1, 0);
    tick(1, 0, 0, 0, 1, 5'd13, 16'd3, 5'd13, 0, 1);
    idle(5'd13, 0);

    // Reset while fading discards the fade.
    phase = "reset_mid";
    tick(1, 0, 0, 0, 1, 5'd31, 16'd1, 5'd13, 1, 0);
    for (int k = 1; k <= 4; k++) strobe(5'(13 + k), 1, 0);
    tick(0, 1, 0, 0, 0, 5'd0, 16'd0, 5'd16, 0, 0);
    idle(5'd16, 0);
    strobe(5'd16, 0, 0);
    idle(5'd16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
